// File: rtl/sort_check_monitor_pkg.sv
// sort_check_monitor_pkg: shared state encoding and constants for the self-check monitor.
// Contents: state_t (S_RUN, S_WALK, S_SIG, S_DONE) and FAIL_SIG, the fail index that
// reports a signature mismatch rather than an ordering violation.
package sort_check_monitor_pkg;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WALK = 2'd1,
    S_SIG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] FAIL_SIG = 6'd63;

endpackage

// File: rtl/sort_check_monitor_order.sv
// order_cmp: combinational pair check; ok = 1 when a may precede b under ORDER.
// Ports: a, b (WIDTH) in; ok out. ORDER 0 = a <= b, 1 = a >= b, 2 = always ok.
// SIGNED_CMP selects two's-complement compare. Equal values always pass.
module order_cmp
  import sort_check_monitor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIGNED_CMP = 0,
  parameter int ORDER      = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ok
);

  logic le_ab;
  logic ge_ab;

  always_comb begin
    if (SIGNED_CMP != 0) begin
      le_ab = ($signed(a) <= $signed(b));
      ge_ab = ($signed(a) >= $signed(b));
    end else begin
      le_ab = (a <= b);
      ge_ab = (a >= b);
    end
    case (ORDER)
      0:       ok = le_ab;
      1:       ok = ge_ab;
      default: ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/sort_check_monitor.sv
// sort_check_monitor: snoops data-memory writes into an N-word shadow window, then on a
// halt write or timeout walks the window for ordering and checks a signature register.
// Ports: clk_i/rst_i (sync, active high), mem_* snoop port, sig_value_i; done/pass/timeout/fail_idx/write_cnt out.
module sort_check_monitor
  import sort_check_monitor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int BASE_ADDR  = 20,
  parameter int N          = 6,
  parameter int ADDR_LSB   = 0,
  parameter int HALT_ADDR  = 1023,
  parameter int TIMEOUT    = 4000,
  parameter int ORDER      = 0,
  parameter int SIGNED_CMP = 0,
  parameter int SIGNATURE  = 12833
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [WIDTH-1:0]  mem_wdata_i,
  input  logic [WIDTH-1:0]  sig_value_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [5:0]        fail_idx_o,
  output logic [15:0]       write_cnt_o
);

  localparam int                IDX_W    = $clog2(N);
  localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LIMIT_W  = ADDR_W'(BASE_ADDR + N);
  localparam logic [ADDR_W-1:0] HALT_W   = ADDR_W'(HALT_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 2);
  localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0]  SIG_W    = WIDTH'(SIGNATURE);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        cyc_q, cyc_d;
  logic               to_hit_q, to_hit_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic [5:0]         fail_idx_q, fail_idx_d;
  logic [15:0]        write_cnt_q, write_cnt_d;
  logic [WIDTH-1:0]   shadow_q [N];
  logic [WIDTH-1:0]   shadow_d [N];

  logic [ADDR_W-1:0]  word_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               is_halt;
  logic               in_win;
  logic               pair_ok;

  assign word_idx = mem_addr_i >> ADDR_LSB;
  assign win_idx  = IDX_W'(word_idx - BASE_W);
  assign idx_nxt  = idx_q + IDX_W'(1);
  assign is_halt  = mem_write_i && (word_idx == HALT_W);
  // A halt write is never stored, even if HALT_ADDR sits inside the window.
  assign in_win   = mem_write_i && !is_halt && (word_idx >= BASE_W) && (word_idx < LIMIT_W);

  order_cmp #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP),
    .ORDER      (ORDER)
  ) u_cmp (
    .a  (shadow_q[idx_q]),
    .b  (shadow_q[idx_nxt]),
    .ok (pair_ok)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cyc_d       = cyc_q;
    to_hit_d    = to_hit_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_idx_d  = fail_idx_q;
    write_cnt_d = write_cnt_q;
    shadow_d    = shadow_q;

    case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (in_win) begin
          shadow_d[win_idx] = mem_wdata_i;
          if (write_cnt_q != 16'hFFFF) write_cnt_d = write_cnt_q + 16'd1;
        end
        // Halt wins over a coincident timeout, so the timeout flag is only
        // latched when no halt arrives in the trigger cycle.
        if (is_halt || (cyc_q == TMO_LAST)) begin
          // With no ordering to check, go straight to the signature so done
          // rises two cycles after the trigger.
          state_d  = (ORDER == 2) ? S_SIG : S_WALK;
          idx_d    = '0;
          to_hit_d = !is_halt;
        end
      end
      S_WALK: begin
        if (!pair_ok) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          pass_d     = 1'b0;
          fail_idx_d = 6'(idx_q);
          timeout_d  = to_hit_q;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_SIG;
        end else begin
          idx_d = idx_nxt;
        end
      end
      S_SIG: begin
        state_d   = S_DONE;
        done_d    = 1'b1;
        timeout_d = to_hit_q;
        if (sig_value_i == SIG_W) begin
          pass_d     = 1'b1;
          fail_idx_d = 6'd0;
        end else begin
          pass_d     = 1'b0;
          fail_idx_d = FAIL_SIG;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      idx_q       <= '0;
      cyc_q       <= '0;
      to_hit_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_idx_q  <= '0;
      write_cnt_q <= '0;
      for (int k = 0; k < N; k++) shadow_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cyc_q       <= cyc_d;
      to_hit_q    <= to_hit_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_idx_q  <= fail_idx_d;
      write_cnt_q <= write_cnt_d;
      shadow_q    <= shadow_d;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign fail_idx_o  = fail_idx_q;
  assign write_cnt_o = write_cnt_q;

endmodule

// File: tb/tb_sort_check_monitor.sv
// tb_sort_check_monitor: directed scenarios against five parameterisations of the monitor
// sharing one snoop bus; each instance has its own reset so it only sees its own scenario.
// Index 0 = ascending default, 1 = TIMEOUT 50, 2 = signed desc, 3 = unsigned desc, 4 = ORDER 2.
module tb_sort_check_monitor;

  logic        clk = 1'b0;
  logic [4:0]  rst_v = 5'b11111;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] sig_value = 32'd12833;

  logic [4:0]  done_v, pass_v, to_v;
  logic [5:0]  fidx_v [5];
  logic [15:0] cnt_v [5];

  logic [31:0] win [6];
  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  sort_check_monitor u_asc (
    .clk_i(clk), .rst_i(rst_v[0]), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .sig_value_i(sig_value), .done_o(done_v[0]), .pass_o(pass_v[0]),
    .timeout_o(to_v[0]), .fail_idx_o(fidx_v[0]), .write_cnt_o(cnt_v[0]));

  sort_check_monitor #(.TIMEOUT(50)) u_tmo (
    .clk_i(clk), .rst_i(rst_v[1]), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .sig_value_i(sig_value), .done_o(done_v[1]), .pass_o(pass_v[1]),
    .timeout_o(to_v[1]), .fail_idx_o(fidx_v[1]), .write_cnt_o(cnt_v[1]));

  sort_check_monitor #(.ORDER(1), .SIGNED_CMP(1)) u_sdesc (
    .clk_i(clk), .rst_i(rst_v[2]), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .sig_value_i(sig_value), .done_o(done_v[2]), .pass_o(pass_v[2]),
    .timeout_o(to_v[2]), .fail_idx_o(fidx_v[2]), .write_cnt_o(cnt_v[2]));

  sort_check_monitor #(.ORDER(1), .SIGNED_CMP(0)) u_udesc (
    .clk_i(clk), .rst_i(rst_v[3]), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .sig_value_i(sig_value), .done_o(done_v[3]), .pass_o(pass_v[3]),
    .timeout_o(to_v[3]), .fail_idx_o(fidx_v[3]), .write_cnt_o(cnt_v[3]));

  sort_check_monitor #(.ORDER(2)) u_noord (
    .clk_i(clk), .rst_i(rst_v[4]), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .sig_value_i(sig_value), .done_o(done_v[4]), .pass_o(pass_v[4]),
    .timeout_o(to_v[4]), .fail_idx_o(fidx_v[4]), .write_cnt_o(cnt_v[4]));

  // Bus drivers: all start and end on a falling edge.
  task automatic do_rst(input int sel);
    @(negedge clk);
    rst_v[sel] = 1'b1;
    @(negedge clk);
    rst_v[sel] = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic wr_win();
    for (int k = 0; k < 6; k++) wr(32'd20 + 32'(k), win[k]);
  endtask

  // Drives the halt write and returns how many rising edges (counting the one
  // that samples the halt) pass before done is seen; -1 if it never rises.
  task automatic do_halt(input int sel, output int l);
    mem_write = 1'b1;
    mem_addr  = 32'd1023;
    mem_wdata = 32'd0;
    l = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      mem_write = 1'b0;
      if (done_v[sel] === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      if (done_v[s] !== 1'b0) begin errors++; $display("FAIL rst_done[%0d]: got %b want 0", s, done_v[s]); end
      checks++;
      if (pass_v[s] !== 1'b0) begin errors++; $display("FAIL rst_pass[%0d]: got %b want 0", s, pass_v[s]); end
      checks++;
      if (to_v[s] !== 1'b0) begin errors++; $display("FAIL rst_timeout[%0d]: got %b want 0", s, to_v[s]); end
      checks++;
      if (fidx_v[s] !== 6'd0) begin errors++; $display("FAIL rst_fail_idx[%0d]: got %0d want 0", s, fidx_v[s]); end
      checks++;
      if (cnt_v[s] !== 16'd0) begin errors++; $display("FAIL rst_cnt[%0d]: got %0d want 0", s, cnt_v[s]); end
      checks++;
    end
  endtask

  task automatic test_ascending();
    do_rst(0);
    sig_value = 32'd12833;
    win = '{32'd1, 32'd3, 32'd3, 32'd7, 32'd9, 32'd12};
    wr_win();
    if (cnt_v[0] !== 16'd6) begin errors++; $display("FAIL asc_cnt_pre: got %0d want 6", cnt_v[0]); end
    checks++;
    do_halt(0, lat);
    if (lat !== 7) begin errors++; $display("FAIL asc_latency: got %0d want 7", lat); end
    checks++;
    if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL asc_pass: got %b want 1", pass_v[0]); end
    checks++;
    if (fidx_v[0] !== 6'd0) begin errors++; $display("FAIL asc_fail_idx: got %0d want 0", fidx_v[0]); end
    checks++;
    if (to_v[0] !== 1'b0) begin errors++; $display("FAIL asc_timeout: got %b want 0", to_v[0]); end
    checks++;
  endtask

  task automatic test_boundary();
    do_rst(0);
    win = '{32'd1, 32'd3, 32'd3, 32'd7, 32'd9, 32'd12};
    wr_win();
    wr(32'd19, 32'd100);
    wr(32'd26, 32'd0);
    if (cnt_v[0] !== 16'd6) begin errors++; $display("FAIL bnd_cnt_edges: got %0d want 6", cnt_v[0]); end
    checks++;
    do_halt(0, lat);
    if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL bnd_pass: got %b want 1", pass_v[0]); end
    checks++;
    wr(32'd21, 32'd0);
    repeat (3) @(negedge clk);
    if (cnt_v[0] !== 16'd6) begin errors++; $display("FAIL bnd_cnt_after_done: got %0d want 6", cnt_v[0]); end
    checks++;
    if ({done_v[0], pass_v[0], fidx_v[0]} !== {1'b1, 1'b1, 6'd0}) begin
      errors++; $display("FAIL bnd_hold: got done=%b pass=%b idx=%0d want 1 1 0", done_v[0], pass_v[0], fidx_v[0]);
    end
    checks++;
  endtask

  task automatic test_unsorted();
    do_rst(0);
    win = '{32'd1, 32'd5, 32'd4, 32'd6, 32'd7, 32'd8};
    wr_win();
    do_halt(0, lat);
    if (lat !== 3) begin errors++; $display("FAIL uns_latency: got %0d want 3", lat); end
    checks++;
    if (pass_v[0] !== 1'b0) begin errors++; $display("FAIL uns_pass: got %b want 0", pass_v[0]); end
    checks++;
    if (fidx_v[0] !== 6'd1) begin errors++; $display("FAIL uns_fail_idx: got %0d want 1", fidx_v[0]); end
    checks++;
  endtask

  task automatic test_sig_mismatch();
    do_rst(0);
    sig_value = 32'd12832;
    win = '{32'd1, 32'd3, 32'd3, 32'd7, 32'd9, 32'd12};
    wr_win();
    do_halt(0, lat);
    if (lat !== 7) begin errors++; $display("FAIL sig_latency: got %0d want 7", lat); end
    checks++;
    if (pass_v[0] !== 1'b0) begin errors++; $display("FAIL sig_pass: got %b want 0", pass_v[0]); end
    checks++;
    if (fidx_v[0] !== 6'd63) begin errors++; $display("FAIL sig_fail_idx: got %0d want 63", fidx_v[0]); end
    checks++;
    sig_value = 32'd12833;
  endtask

  task automatic test_timeout();
    do_rst(1);
    repeat (55) @(negedge clk);
    if (done_v[1] !== 1'b0) begin errors++; $display("FAIL tmo_done_early: got %b want 0", done_v[1]); end
    checks++;
    if (to_v[1] !== 1'b0) begin errors++; $display("FAIL tmo_flag_early: got %b want 0", to_v[1]); end
    checks++;
    @(negedge clk);
    if (done_v[1] !== 1'b1) begin errors++; $display("FAIL tmo_done_56: got %b want 1", done_v[1]); end
    checks++;
    if (to_v[1] !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", to_v[1]); end
    checks++;
    if (pass_v[1] !== 1'b1) begin errors++; $display("FAIL tmo_pass: got %b want 1", pass_v[1]); end
    checks++;
    if (cnt_v[1] !== 16'd0) begin errors++; $display("FAIL tmo_cnt: got %0d want 0", cnt_v[1]); end
    checks++;
  endtask

  task automatic test_halt_at_timeout();
    do_rst(1);
    repeat (49) @(negedge clk);
    do_halt(1, lat);
    if (lat !== 7) begin errors++; $display("FAIL halt_tmo_latency: got %0d want 7", lat); end
    checks++;
    if (to_v[1] !== 1'b0) begin errors++; $display("FAIL halt_tmo_flag: got %b want 0", to_v[1]); end
    checks++;
    if (pass_v[1] !== 1'b1) begin errors++; $display("FAIL halt_tmo_pass: got %b want 1", pass_v[1]); end
    checks++;
  endtask

  task automatic test_signed_desc();
    rst_v[2] = 1'b1;
    rst_v[3] = 1'b1;
    @(negedge clk);
    rst_v[2] = 1'b0;
    rst_v[3] = 1'b0;
    win = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF8};
    wr_win();
    do_halt(2, lat);
    if (lat !== 7) begin errors++; $display("FAIL sdesc_latency: got %0d want 7", lat); end
    checks++;
    if (pass_v[2] !== 1'b1) begin errors++; $display("FAIL sdesc_pass: got %b want 1", pass_v[2]); end
    checks++;
    if ({done_v[3], pass_v[3]} !== 2'b10) begin
      errors++; $display("FAIL udesc_done_pass: got done=%b pass=%b want 1 0", done_v[3], pass_v[3]);
    end
    checks++;
    if (fidx_v[3] !== 6'd1) begin errors++; $display("FAIL udesc_fail_idx: got %0d want 1", fidx_v[3]); end
    checks++;
  endtask

  task automatic test_no_order();
    do_rst(4);
    win = '{32'd9, 32'd2, 32'd7, 32'd1, 32'd0, 32'd5};
    wr_win();
    do_halt(4, lat);
    if (lat !== 2) begin errors++; $display("FAIL noord_latency: got %0d want 2", lat); end
    checks++;
    if (pass_v[4] !== 1'b1) begin errors++; $display("FAIL noord_pass: got %b want 1", pass_v[4]); end
    checks++;
  endtask

  task automatic test_reset_mid_walk();
    do_rst(0);
    win = '{32'd1, 32'd3, 32'd3, 32'd7, 32'd9, 32'd12};
    wr_win();
    if (cnt_v[0] !== 16'd6) begin errors++; $display("FAIL mid_cnt_pre: got %0d want 6", cnt_v[0]); end
    checks++;
    mem_write = 1'b1;
    mem_addr  = 32'd1023;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    if ({done_v[0], pass_v[0], to_v[0], fidx_v[0], cnt_v[0]} !== 25'd0) begin
      errors++; $display("FAIL mid_rst_outputs: got done=%b pass=%b to=%b idx=%0d cnt=%0d want all 0",
                         done_v[0], pass_v[0], to_v[0], fidx_v[0], cnt_v[0]);
    end
    checks++;
    rst_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    if (done_v[0] !== 1'b0) begin errors++; $display("FAIL mid_abort: got done=%b want 0", done_v[0]); end
    checks++;
    wr_win();
    do_halt(0, lat);
    if (lat !== 7) begin errors++; $display("FAIL mid_rerun_latency: got %0d want 7", lat); end
    checks++;
    if ({pass_v[0], fidx_v[0], cnt_v[0]} !== {1'b1, 6'd0, 16'd6}) begin
      errors++; $display("FAIL mid_rerun_result: got pass=%b idx=%0d cnt=%0d want 1 0 6", pass_v[0], fidx_v[0], cnt_v[0]);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_boundary();
    test_unsorted();
    test_sig_mismatch();
    test_timeout();
    test_halt_at_timeout();
    test_signed_desc();
    test_no_order();
    test_reset_mid_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
